// File: rtl/key_scanner.sv
`default_nettype none
// ============================================================================
// Module   : key_scanner
// Purpose  : 4x4 active-low key matrix scanner with frame debounce and
//            single-key press events. Optional auto-repeat: KEY_SCANNER_REPEAT_EN.
// Revision : 1.0  initial release
// ============================================================================
module key_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int REPEAT_FRAMES   = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] c_DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] c_DEB_SAT    = SW'(DEBOUNCE_FRAMES);
    localparam logic [SW-1:0] c_DEB_ONE    = SW'(1);

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_PRESSED = 1'b1;
    typedef enum logic [0:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_PRESSED = c_ST_PRESSED
    } state_t;

    generate
        if (SCAN_DIV < 2) begin : g_bad_scan_div
            $error("key_scanner: SCAN_DIV must be >= 2");
        end
        if (DEBOUNCE_FRAMES < 1) begin : g_bad_debounce
            $error("key_scanner: DEBOUNCE_FRAMES must be >= 1");
        end
        if (REPEAT_FRAMES < 1) begin : g_bad_repeat
            $error("key_scanner: REPEAT_FRAMES must be >= 1");
        end
    endgenerate

    logic [DW-1:0] r_dwell;
    logic [1:0]    r_col;
    logic [15:0]   r_snap;
    logic [15:0]   r_prev;
    logic [SW-1:0] r_stable;

    logic          w_tick;
    logic          w_frame_end;
    logic [15:0]   w_snap_full;
    logic [SW-1:0] w_stable_next;
    logic          w_accept;
    logic          w_any;
    logic          w_one;
    logic [3:0]    w_idx;
    logic [3:0]    w_code;

    assign w_tick      = (r_dwell == c_DWELL_LAST);
    assign w_frame_end = w_tick && (r_col == 2'd3);
    assign col_out     = ~(4'b0001 << r_col);

    // The last column is sampled on the frame-end tick itself, so splice it in.
    always_comb begin
        w_snap_full        = r_snap;
        w_snap_full[15:12] = ~row_in;
    end

    always_comb begin
        w_stable_next = c_DEB_ONE;
        if (w_snap_full == r_prev) begin
            w_stable_next = (r_stable == c_DEB_SAT) ? c_DEB_SAT : r_stable + 1'b1;
        end
    end

    assign w_accept = w_frame_end && (w_stable_next == c_DEB_SAT);
    assign w_any    = |w_snap_full;
    assign w_one    = w_any && ((w_snap_full & (w_snap_full - 16'd1)) == 16'd0);

    always_comb begin
        w_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_snap_full[i]) w_idx = i[3:0];
        end
    end

    // Snapshot bit index is col*4+row; the reported code is row*4+col.
    assign w_code = {w_idx[1:0], w_idx[3:2]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dwell  <= '0;
            r_col    <= 2'd0;
            r_snap   <= 16'd0;
            r_prev   <= 16'd0;
            r_stable <= '0;
        end else if (w_tick) begin
            r_dwell                  <= '0;
            r_col                    <= r_col + 2'd1;
            r_snap[{r_col, 2'b00} +: 4] <= ~row_in;
            if (w_frame_end) begin
                r_prev   <= w_snap_full;
                r_stable <= w_stable_next;
            end
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_key_code;
    logic [3:0] w_code_next;
    logic       r_key_valid;
    logic       w_valid_next;
    logic       r_key_down;
    logic       w_down_next;

`ifdef KEY_SCANNER_REPEAT_EN
    localparam int RW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    localparam logic [RW-1:0] c_REP_LAST = RW'(REPEAT_FRAMES - 1);
    logic [RW-1:0] r_rep;
    logic [RW-1:0] w_rep_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
`ifdef KEY_SCANNER_REPEAT_EN
            r_rep       <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_key_code  <= w_code_next;
            r_key_valid <= w_valid_next;
            r_key_down  <= w_down_next;
`ifdef KEY_SCANNER_REPEAT_EN
            r_rep       <= w_rep_next;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_key_code;
        w_valid_next = 1'b0;
        w_down_next  = r_key_down;
`ifdef KEY_SCANNER_REPEAT_EN
        w_rep_next   = r_rep;
`endif
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_one) begin
                        w_state_next = ST_PRESSED;
                        w_code_next  = w_code;
                        w_valid_next = 1'b1;
                        w_down_next  = 1'b1;
`ifdef KEY_SCANNER_REPEAT_EN
                        w_rep_next   = '0;
`endif
                    end
                end
                ST_PRESSED: begin
                    if (!w_any) begin
                        w_state_next = ST_IDLE;
                        w_down_next  = 1'b0;
`ifdef KEY_SCANNER_REPEAT_EN
                        w_rep_next   = '0;
`endif
                    end else if (w_one && (w_code != r_key_code)) begin
                        w_code_next  = w_code;
                        w_valid_next = 1'b1;
`ifdef KEY_SCANNER_REPEAT_EN
                        w_rep_next   = '0;
                    end else if (w_one) begin
                        if (r_rep == c_REP_LAST) begin
                            w_valid_next = 1'b1;
                            w_rep_next   = '0;
                        end else begin
                            w_rep_next = r_rep + 1'b1;
                        end
`endif
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_down  = r_key_down;

endmodule
`default_nettype wire

// File: tb/tb_key_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_scanner
// Purpose  : Scoreboard bench for key_scanner with a behavioural key matrix.
// Revision : 1.0  initial release
// ============================================================================
module tb_key_scanner;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_FRAMES = 2;
    localparam int REPEAT_FRAMES   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    // Pressed keys, indexed by key code row*4+col.
    logic [15:0] keys = 16'd0;

    int checks    = 0;
    int failures  = 0;
    int pulses    = 0;
    int exp_total = 0;
    logic [3:0] exp_q[$];
    logic       prev_valid = 1'b0;

    key_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .REPEAT_FRAMES   (REPEAT_FRAMES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col_out[c] && keys[r*4 + c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_pulse(input logic [3:0] code);
        exp_q.push_back(code);
        exp_total++;
    endtask

    // Returns #1 after the edge on which col_out wraps 0111 -> 1110.
    task automatic next_frame();
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        prev  = col_out;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (prev == 4'b0111 && col_out == 4'b1110) found = 1'b1;
            prev = col_out;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: actual=no frame wrap required=wrap within 40 cycles");
        end
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < n; i++) next_frame();
    endtask

    // Monitor: every key_valid pulse is matched against the next expected event.
    always @(negedge clk) begin
        if (key_valid) begin
            pulses++;
            check("valid_gap", 16'(prev_valid), 16'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: actual key_code=%0d required=no pulse", key_code);
            end else begin
                check("pulse_key_code", 16'(key_code), 16'(exp_q.pop_front()));
                check("pulse_key_down", 16'(key_down), 16'd1);
            end
        end
        prev_valid = key_valid;
    end

    initial begin
        logic [3:0] ecol;

        rst_n = 1'b0;
        keys  = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_col_out",   16'(col_out),   16'h000E);
        check("reset_key_code",  16'(key_code),  16'd0);
        check("reset_key_valid", 16'(key_valid), 16'd0);
        check("reset_key_down",  16'(key_down),  16'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            ecol = ~(4'b0001 << (k / 4));
            check("col_scan", 16'(col_out), 16'(ecol));
            check("idle_outputs", 16'({key_valid, key_down, key_code}), 16'd0);
            @(posedge clk);
            #1;
        end

        // Single press: key 9 (row 2, col 1) from frame start.
        keys = 16'd1 << 9;
        expect_pulse(4'd9);
        wait_frames(3);
        check("press_key_code", 16'(key_code), 16'd9);
        check("press_key_down", 16'(key_down), 16'd1);
        check("press_pending",  16'(exp_q.size()), 16'd0);

        // Add key 6 while 9 is held: ignored.
        keys = keys | (16'd1 << 6);
        wait_frames(3);
        check("multi_key_code", 16'(key_code), 16'd9);
        check("multi_key_down", 16'(key_down), 16'd1);

        // Release: key_down falls on the second all-zero frame end.
        keys = 16'd0;
        wait_frames(1);
        check("release_first_frame",  16'(key_down), 16'd1);
        wait_frames(1);
        check("release_second_frame", 16'(key_down), 16'd0);

        // Bounce on key 0, then a stable hold.
        for (int f = 0; f < 6; f++) begin
            keys = (f % 2 == 0) ? 16'd1 : 16'd0;
            next_frame();
        end
        keys = 16'd1;
        expect_pulse(4'd0);
        wait_frames(3);
        check("bounce_key_code", 16'(key_code), 16'd0);
        check("bounce_key_down", 16'(key_down), 16'd1);

        // Key change 0 -> 3 -> 12 without release.
        keys = 16'd1 << 3;
        expect_pulse(4'd3);
        wait_frames(3);
        check("change_key3_code", 16'(key_code), 16'd3);
        keys = 16'd1 << 12;
        expect_pulse(4'd12);
        wait_frames(3);
        check("change_key12_code", 16'(key_code), 16'd12);
        check("change_key12_down", 16'(key_down), 16'd1);
        keys = 16'd0;
        wait_frames(3);
        check("change_release_down", 16'(key_down), 16'd0);

        // Long hold of key 5: accepted at frame end 2, repeats at 5, 8, 11.
        keys = 16'd1 << 5;
        expect_pulse(4'd5);
`ifdef KEY_SCANNER_REPEAT_EN
        expect_pulse(4'd5);
        expect_pulse(4'd5);
        expect_pulse(4'd5);
`endif
        wait_frames(12);
        check("hold_key_code", 16'(key_code), 16'd5);
        check("hold_key_down", 16'(key_down), 16'd1);
        keys = 16'd0;
        wait_frames(3);
        check("hold_release_down", 16'(key_down), 16'd0);

        check("pending_events", 16'(exp_q.size()), 16'd0);
        check("pulse_count",    16'(pulses),       16'(exp_total));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_scanner.md
# key_scanner

Scans a 4x4 active-low key matrix and reports debounced single-key press events to the control FSM; it is the input-side counterpart of the time-multiplexed seven-segment driver. It drives the matrix columns one at a time, samples the rows, and builds a full-frame snapshot. It filters bounce across frames and emits a one-cycle `key_valid` pulse with a 4-bit key code on each new press. It sits between the board's key pins and the state machine that selects the display modes.

## Interface
- `SCAN_DIV`, default 50000: clk cycles each column is driven (dwell); must be ≥ 2.
- `DEBOUNCE_FRAMES`, default 3: consecutive identical frames required before a snapshot is accepted; must be ≥ 1.
- `REPEAT_FRAMES`, default 60: hold time in frames before auto-repeat, and the repeat period. Used only with `KEY_SCANNER_REPEAT_EN`.
- `clk`  in  1: system clock, the only clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `row_in`  in  4: matrix rows, active-low, externally pulled up. Used directly with no synchronizer stage.
- `col_out`  out  4: column drive, active-low one-hot.
- `key_code`  out  4: code of the last accepted key, `row*4 + col`.
- `key_valid`  out  1: one-cycle pulse when `key_code` takes a new event.
- `key_down`  out  1: high while the accepted key is held.

## Operation
- **Dwell counter:** runs 0..SCAN_DIV-1; `tick` is asserted when it reaches SCAN_DIV-1.
- **Column index:** 2-bit `col`, advances on `tick` and wraps 3→0. `col_out = ~(4'b0001 << col)`.
- **Row sampling:** on `tick`, `~row_in` is written into snapshot bits `[col*4 +: 4]` (bit index = col*4+row), after the full dwell has elapsed.
- **Frame end:** the `tick` with col==3. At this point the working snapshot is compared with the previous frame's snapshot.
  - Equal: stability counter increments, saturating at DEBOUNCE_FRAMES.
  - Different: stability counter is set to 1.
  - Either way, the working snapshot becomes the previous snapshot.
- **Accepted frame:** a frame end where the stability counter reaches (or stays at) DEBOUNCE_FRAMES.
- **FSM states:**
  - IDLE:
    - Accepted frame with exactly one bit set → PRESSED, `key_code` ← bit index, `key_valid` pulse, `key_down` ← 1.
    - Zero bits or ≥2 bits → stay in IDLE, no event.
  - PRESSED:
    - Accepted frame with zero bits → IDLE, `key_down` ← 0.
    - Same single key → stay in PRESSED.
    - A different single key → stay in PRESSED, new `key_code`, `key_valid` pulse.
    - ≥2 bits → stay in PRESSED, outputs unchanged (multi-key and ghosting are ignored).
- `key_valid` fires only at a frame end, never twice in consecutive cycles.

## Timing
- **Reset values:** `col_out`=4'b1110, `key_code`=0, `key_valid`=0, `key_down`=0. FSM=IDLE; dwell counter, `col`, both snapshots and the stability counter are all 0.
- Frame period = 4*SCAN_DIV cycles.
- `key_valid` and `key_down` are registered and assert in the cycle after the accepting frame-end `tick`.
- **Press latency:** a press stable before a frame start is reported after DEBOUNCE_FRAMES+1 frame ends at most, plus 1 cycle.
- **Release:** `key_down` falls DEBOUNCE_FRAMES frame ends after the first all-zero frame, plus 1 cycle.
- **Reset mid-frame:** everything returns to reset values on the next edge; the partial snapshot is discarded.
- A change to `row_in` during a dwell is visible only if it is present at `tick`.

## Configuration
- **`KEY_SCANNER_REPEAT_EN` defined:**
  - While in PRESSED on the same key, a repeat counter counts accepted frames.
  - At REPEAT_FRAMES it emits `key_valid` with the unchanged `key_code`, then reloads to 0 and repeats every REPEAT_FRAMES accepted frames.
  - The counter clears on any key change, on release, and on reset.
- **Not defined:** no repeat counter logic; exactly one `key_valid` per press.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_FRAMES=2, REPEAT_FRAMES=3 (frame = 16 cycles).
- **Reset:** hold `rst_n`=0 for 3 cycles, `row_in`=4'hF. After release, `col_out` sequence is 1110,1101,1011,0111 with 4 cycles each, and all outputs stay 0.
- **Single press:** pull row 2 low only while col 1 is driven, held from frame start. Exactly one `key_valid` pulse, `key_code`=9, `key_down`=1, within 3 frames + 1 cycle.
- **Bounce:** toggle row 0/col 0 on alternating frames for 6 frames, then hold. No pulse during the toggling; one pulse with `key_code`=0 after 2 stable frame ends.
- **Release and multi-key:**
  - While key 9 is held, add key 6: no pulse, `key_code` stays 9.
  - Release both: `key_down`→0 after 2 all-zero frames.
- **Key change:** go from key 3 held directly to key 12 held. Second pulse with `key_code`=12, `key_down` stays 1.
- **Repeat (`KEY_SCANNER_REPEAT_EN`):** hold key 5 for 12 frames. Initial pulse, then repeat pulses every 3 accepted frames, all with `key_code`=5. Without the macro, only one pulse.
